// File: rtl/frame_deserializer.sv
// Serial-to-parallel frame receiver with inter-frame gap enforcement,
// a one-deep valid/ready output register, abort and overrun reporting.
module frame_deserializer #(
    parameter int FRAME_W    = 71,
    parameter int GAP_CYCLES = 2,
    parameter bit LSB_FIRST  = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         rx_enable,
    input  logic                         bit_in,
    output logic [FRAME_W-1:0]           frame_data,
    output logic                         frame_valid,
    input  logic                         frame_ready,
    output logic                         busy,
    output logic [$clog2(FRAME_W+1)-1:0] bit_count,
    output logic                         abort_pulse,
    output logic                         overrun
);

    localparam int CW = $clog2(FRAME_W + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    state_t             state;
    logic [FRAME_W-1:0] shreg;
    logic [FRAME_W-1:0] shift_next;
    logic [CW-1:0]      count;
    logic [GW-1:0]      gap_cnt;
    logic               capture;
    logic               last;

    // count holds bits captured before this cycle; bit_count includes
    // the bit being captured now, so it reads 1..FRAME_W across a frame.
    always_comb begin
        capture = rx_enable && (state == IDLE || state == SHIFT);
        last    = capture && (count == CW'(FRAME_W - 1));
        if (LSB_FIRST)
            shift_next = {bit_in, shreg[FRAME_W-1:1]};
        else
            shift_next = {shreg[FRAME_W-2:0], bit_in};
        bit_count = (capture && !reset) ? count + 1'b1 : '0;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            shreg       <= '0;
            count       <= '0;
            gap_cnt     <= '0;
            abort_pulse <= 1'b0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            abort_pulse <= 1'b0;
            unique case (state)
                IDLE, SHIFT: begin
                    if (last) begin
                        shreg   <= '0;
                        count   <= '0;
                        gap_cnt <= '0;
                        state   <= (GAP_CYCLES > 0) ? GAP : IDLE;
                    end else if (capture) begin
                        shreg <= shift_next;
                        count <= count + 1'b1;
                        state <= SHIFT;
                    end else begin
                        shreg       <= '0;
                        count       <= '0;
                        abort_pulse <= (state == SHIFT);
                        state       <= IDLE;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
                    if (gap_cnt == GW'(GAP_LAST))
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // A completing frame may replace one that transfers this cycle.
            if (last) begin
                if (!frame_valid || frame_ready) begin
                    frame_data  <= shift_next;
                    frame_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_frame_deserializer.sv
// Bench for frame_deserializer: three configurations driven in lockstep,
// directed scenarios plus random traffic against a behavioural model.
module tb_frame_deserializer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rx_enable = 1'b0;
    logic bit_in = 1'b0;
    logic frame_ready = 1'b0;

    always #5 clk = ~clk;

    logic [7:0]  fd_a, fd_b;
    logic [70:0] fd_c;
    logic        fv_a, fv_b, fv_c;
    logic        bz_a, bz_b, bz_c;
    logic [3:0]  bc_a, bc_b;
    logic [6:0]  bc_c;
    logic        ab_a, ab_b, ab_c;
    logic        ov_a, ov_b, ov_c;

    frame_deserializer #(.FRAME_W(8), .GAP_CYCLES(2), .LSB_FIRST(1'b0)) u_a (
        .clk(clk), .reset(reset), .rx_enable(rx_enable), .bit_in(bit_in),
        .frame_data(fd_a), .frame_valid(fv_a), .frame_ready(frame_ready),
        .busy(bz_a), .bit_count(bc_a), .abort_pulse(ab_a), .overrun(ov_a)
    );

    frame_deserializer #(.FRAME_W(8), .GAP_CYCLES(0), .LSB_FIRST(1'b1)) u_b (
        .clk(clk), .reset(reset), .rx_enable(rx_enable), .bit_in(bit_in),
        .frame_data(fd_b), .frame_valid(fv_b), .frame_ready(frame_ready),
        .busy(bz_b), .bit_count(bc_b), .abort_pulse(ab_b), .overrun(ov_b)
    );

    frame_deserializer #(.FRAME_W(71), .GAP_CYCLES(2), .LSB_FIRST(1'b0)) u_c (
        .clk(clk), .reset(reset), .rx_enable(rx_enable), .bit_in(bit_in),
        .frame_data(fd_c), .frame_valid(fv_c), .frame_ready(frame_ready),
        .busy(bz_c), .bit_count(bc_c), .abort_pulse(ab_c), .overrun(ov_c)
    );

    int checks = 0;
    int failures = 0;
    int bc_seen [3];

    // Model: bits collected so far, gap cycles left, output slot.
    int           cnt  [3];
    int           gapl [3];
    logic [254:0] acc  [3];
    logic [254:0] hold [3];
    bit           hv   [3];
    bit           ovr  [3];
    bit           ab   [3];

    function automatic int wof(int i);
        return (i == 2) ? 71 : 8;
    endfunction

    function automatic int gof(int i);
        return (i == 1) ? 0 : 2;
    endfunction

    function automatic bit lof(int i);
        return (i == 1);
    endfunction

    task automatic chk(input string tag, input logic [254:0] obs,
                       input logic [254:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_one(input int i, input logic r, input logic b,
                             input logic rdy);
        bit done = 1'b0;
        logic [254:0] fr = '0;
        if (reset) begin
            cnt[i] = 0; gapl[i] = 0; acc[i] = '0; hold[i] = '0;
            hv[i] = 1'b0; ovr[i] = 1'b0; ab[i] = 1'b0;
            return;
        end
        ab[i] = 1'b0;
        if (gapl[i] > 0) begin
            gapl[i]--;
        end else if (!r) begin
            if (cnt[i] > 0) ab[i] = 1'b1;
            cnt[i] = 0;
            acc[i] = '0;
        end else begin
            if (lof(i)) acc[i][cnt[i]] = b;
            else acc[i] = (acc[i] << 1) | 255'(b);
            cnt[i]++;
            if (cnt[i] == wof(i)) begin
                done = 1'b1; fr = acc[i];
                cnt[i] = 0; acc[i] = '0; gapl[i] = gof(i);
            end
        end
        if (done) begin
            if (!hv[i] || rdy) begin hold[i] = fr; hv[i] = 1'b1; end
            else ovr[i] = 1'b1;
        end else if (hv[i] && rdy) begin
            hv[i] = 1'b0;
        end
    endtask

    task automatic check_one(input int i, input logic [254:0] fd,
                             input logic fv, input logic bz, input int bc,
                             input logic abo, input logic ov);
        int ebc = (!reset && gapl[i] == 0 && rx_enable) ? cnt[i] + 1 : 0;
        string s = $sformatf("u%0d", i);
        chk({s, ".frame_data"}, fd, hold[i]);
        chk({s, ".frame_valid"}, 255'(fv), 255'(hv[i]));
        chk({s, ".busy"}, 255'(bz), 255'(cnt[i] > 0 || gapl[i] > 0));
        chk({s, ".bit_count"}, 255'(bc), 255'(ebc));
        chk({s, ".abort_pulse"}, 255'(abo), 255'(ab[i]));
        chk({s, ".overrun"}, 255'(ov), 255'(ovr[i]));
        bc_seen[i] = bc;
    endtask

    // Called just after a posedge: drive, check mid-cycle, then step model.
    task automatic cyc(input logic r, input logic b, input logic rdy);
        rx_enable = r; bit_in = b; frame_ready = rdy;
        @(negedge clk);
        check_one(0, 255'(fd_a), fv_a, bz_a, 32'(bc_a), ab_a, ov_a);
        check_one(1, 255'(fd_b), fv_b, bz_b, 32'(bc_b), ab_b, ov_b);
        check_one(2, 255'(fd_c), fv_c, bz_c, 32'(bc_c), ab_c, ov_c);
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_one(i, r, b, rdy);
        #1;
    endtask

    task automatic send8(input logic [7:0] v, input logic rdy_rest,
                         input logic rdy_last);
        for (int k = 7; k >= 0; k--)
            cyc(1'b1, v[k], (k == 0) ? rdy_last : rdy_rest);
    endtask

    initial begin
        logic [7:0]  pat;
        logic [7:0]  w2;
        logic [70:0] w71;
        logic        b;
        int          bcs [20];

        reset = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_one(i, 1'b0, 1'b0, 1'b0);
        #1;
        cyc(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        chk("reset.frame_valid", 255'(fv_a), 255'(0));
        chk("reset.overrun", 255'(ov_c), 255'(0));
        cyc(1'b0, 1'b0, 1'b1);

        // MSB-first 0xB2 on u_a, same bits LSB-first give 0x4D on u_b
        pat = 8'b1011_0010;
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, pat[7-k], 1'b1);
            chk("seq.bit_count", 255'(bc_seen[0]), 255'(k + 1));
        end
        chk("msb.frame_data", 255'(fd_a), 255'(8'hB2));
        chk("msb.frame_valid", 255'(fv_a), 255'(1));
        chk("lsb.frame_data", 255'(fd_b), 255'(8'h4D));
        cyc(1'b0, 1'b0, 1'b1);
        chk("msb.valid_one_cycle", 255'(fv_a), 255'(0));
        chk("seq.bit_count_end", 255'(bc_seen[0]), 255'(0));
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b1);

        // rx_enable held high: gap cycles ignore bits
        w2 = '0;
        for (int t = 0; t < 20; t++) begin
            b = 1'($urandom);
            if (t >= 10 && t < 18) w2 = {w2[6:0], b};
            cyc(1'b1, b, 1'b1);
            bcs[t] = bc_seen[0];
            if (t == 17) chk("gap.frame2", 255'(fd_a), 255'(w2));
        end
        chk("gap.start0", 255'(bcs[0]), 255'(1));
        chk("gap.last_bit", 255'(bcs[7]), 255'(8));
        chk("gap.ignored0", 255'(bcs[8]), 255'(0));
        chk("gap.ignored1", 255'(bcs[9]), 255'(0));
        chk("gap.start10", 255'(bcs[10]), 255'(1));
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b1);

        // 71-bit abort after 30 bits, then a full frame
        for (int k = 0; k < 30; k++) cyc(1'b1, 1'($urandom), 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        chk("abort.pulse", 255'(ab_c), 255'(1));
        chk("abort.bit_count", 255'(bc_seen[2]), 255'(0));
        chk("abort.no_valid", 255'(fv_c), 255'(0));
        cyc(1'b0, 1'b0, 1'b1);
        chk("abort.one_cycle", 255'(ab_c), 255'(0));
        w71 = '0;
        for (int k = 0; k < 71; k++) begin
            b = 1'($urandom);
            w71 = {w71[69:0], b};
            cyc(1'b1, b, 1'b1);
        end
        chk("w71.frame_data", 255'(fd_c), 255'(w71));
        chk("w71.frame_valid", 255'(fv_c), 255'(1));
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b1);

        // overrun with downstream stalled, then transfer + load together
        send8(8'h5A, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        send8(8'hC3, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("ovr.kept_A", 255'(fd_a), 255'(8'h5A));
        chk("ovr.overrun", 255'(ov_a), 255'(1));
        send8(8'h3C, 1'b0, 1'b1);
        chk("ovr.loaded_C", 255'(fd_a), 255'(8'h3C));
        chk("ovr.valid_C", 255'(fv_a), 255'(1));
        chk("ovr.sticky", 255'(ov_a), 255'(1));

        // reset mid-shift with a frame pending
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) cyc(1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        chk("rst.frame_data", 255'(fd_a), 255'(0));
        chk("rst.frame_valid", 255'(fv_a), 255'(0));
        chk("rst.overrun", 255'(ov_a), 255'(0));
        chk("rst.busy", 255'(bz_a), 255'(0));
        chk("rst.no_abort", 255'(ab_a), 255'(0));
        send8(8'hE7, 1'b1, 1'b1);
        chk("rst.next_frame", 255'(fd_a), 255'(8'hE7));

        // random traffic
        for (int k = 0; k < 2500; k++) begin
            reset = ($urandom_range(0, 299) == 0);
            cyc(($urandom_range(0, 49) != 0), 1'($urandom),
                1'($urandom));
        end
        reset = 1'b0;
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
